// File: rtl/vd_seq_pkg.sv
// Purpose : shared types and constants for the loopback frame sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package vd_seq_pkg;

   // Sequencer states; the 3-bit encoding leaves no spare codes.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FLUSH   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_SEND    = 3'd3,
      ST_WAIT_TX = 3'd4,
      ST_WAIT_RX = 3'd5,
      ST_CHECK   = 3'd6,
      ST_DONE    = 3'd7
   } state_e;

   localparam int VD_CNT_W        = 8;
   localparam int VD_FLUSH_CYCLES = 4;

   // The flush counter must hold the value FLUSH_CYCLES itself.
   function automatic int flush_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   localparam int FLUSH_CNT_W = flush_cnt_w(VD_FLUSH_CYCLES);

   // Saturation value of the error counter.
   localparam logic [VD_CNT_W-1:0] ERR_MAX = {VD_CNT_W{1'b1}};

endpackage

// File: rtl/vd_seq_watchdog.sv
// Purpose : receive watchdog; loadable down-counter, expires TIMEOUT_CYCLES-1
//           cycles after the clear cycle when enabled every cycle in between.
// Latency : o_expire is combinational from the counter state.
// Backpressure: none; i_en simply pauses counting.
// Ports   : i_clk, i_rst_n  clock / async active-low reset
//           i_clr            reload the counter (issued in the launch cycle)
//           i_en             count down this cycle
//           o_expire         counter exhausted while enabled
module vd_seq_watchdog #(
   parameter int TIMEOUT_W      = 20,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   // The clear cycle is elapsed count 0 and the first enabled cycle is 1, so
   // loading TIMEOUT_CYCLES-2 hits zero exactly at elapsed TIMEOUT_CYCLES-1.
   localparam logic [TIMEOUT_W-1:0] LOAD_VAL = TIMEOUT_W'(TIMEOUT_CYCLES - 2);

   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = LOAD_VAL;
      end else if (i_en && (cnt_q != '0)) begin
         cnt_d = cnt_q - TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= LOAD_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expire = i_en && (cnt_q == '0);

endmodule

// File: rtl/vd_loopback_sequencer.sv
// Purpose : per-byte loopback sequencer: flush codec, launch TX, await RX with
//           watchdog, compare, count bytes / errors / timeouts.
// Latency : all outputs registered; o_done appears one cycle after DONE state.
// Backpressure: o_byte_ready only in LOAD; waits indefinitely for i_byte_valid.
// Ports   : i_start/i_abort/i_num_bytes run control; i_byte_valid/i_byte_data
//           with o_byte_ready source stream; o_tx_en/o_tx_data/i_tx_done TX;
//           o_rx_en/i_rx_done/i_rx_data RX; o_codec_rst_n codec flush;
//           o_busy/o_done/o_byte_cnt/o_err_cnt/o_timeout/o_last_rx status.
module vd_loopback_sequencer
   import vd_seq_pkg::*;
#(
   parameter int SIZE_DATA      = 8,
   parameter int CNT_W          = VD_CNT_W,
   parameter int FLUSH_CYCLES   = VD_FLUSH_CYCLES,
   parameter int TIMEOUT_W      = 20,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [CNT_W-1:0]     i_num_bytes,
   input  logic                 i_byte_valid,
   input  logic [SIZE_DATA-1:0] i_byte_data,
   output logic                 o_byte_ready,
   output logic                 o_tx_en,
   output logic [SIZE_DATA-1:0] o_tx_data,
   input  logic                 i_tx_done,
   output logic                 o_rx_en,
   input  logic                 i_rx_done,
   input  logic [SIZE_DATA-1:0] i_rx_data,
   output logic                 o_codec_rst_n,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CNT_W-1:0]     o_byte_cnt,
   output logic [CNT_W-1:0]     o_err_cnt,
   output logic                 o_timeout,
   output logic [SIZE_DATA-1:0] o_last_rx
);

   localparam int               FCW        = flush_cnt_w(FLUSH_CYCLES);
   localparam logic [FCW-1:0]   FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   state_e state_q, state_d;

   logic codec_rst_n_q, codec_rst_n_d;
   logic tx_en_q, tx_en_d;
   logic rx_en_q, rx_en_d;
   logic byte_ready_q, byte_ready_d;
   logic busy_q, busy_d;
   logic done_q, done_d;

   logic [CNT_W-1:0]     num_q, num_d;
   logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
   logic                 timeout_q, timeout_d;
   logic [SIZE_DATA-1:0] tx_data_q, tx_data_d;
   logic [SIZE_DATA-1:0] last_rx_q, last_rx_d;
   logic                 rx_pend_q, rx_pend_d;
   logic [SIZE_DATA-1:0] rx_pend_dat_q, rx_pend_dat_d;
   logic                 tmo_frm_q, tmo_frm_d;
   logic [FCW-1:0]       flush_cnt_q;

   logic                 wd_clr, wd_en, wd_expire;
   logic                 rx_hit;
   logic [SIZE_DATA-1:0] rx_byte;
   logic [CNT_W-1:0]     err_inc;

   // A done pulse latched during WAIT_TX takes priority over a fresh one.
   assign rx_hit  = i_rx_done | rx_pend_q;
   assign rx_byte = rx_pend_q ? rx_pend_dat_q : i_rx_data;
   assign err_inc = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_W'(1);

   assign wd_clr = (state_q == ST_SEND);
   assign wd_en  = (state_q == ST_WAIT_TX) || (state_q == ST_WAIT_RX);

   vd_seq_watchdog #(
      .TIMEOUT_W      (TIMEOUT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (wd_clr),
      .i_en     (wd_en),
      .o_expire (wd_expire)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (i_abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    if (i_start) state_d = (i_num_bytes == '0) ? ST_DONE : ST_FLUSH;
            ST_FLUSH:   if (flush_cnt_q == FLUSH_LAST) state_d = ST_LOAD;
            ST_LOAD:    if (i_byte_valid) state_d = ST_SEND;
            ST_SEND:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: begin
               if (wd_expire)      state_d = ST_CHECK;
               else if (i_tx_done) state_d = ST_WAIT_RX;
            end
            ST_WAIT_RX: if (rx_hit || wd_expire) state_d = ST_CHECK;
            ST_CHECK:   state_d = ((byte_cnt_q + CNT_W'(1)) == num_q) ? ST_DONE : ST_FLUSH;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // Decoded from the next state so each registered output lines up with the
   // state it belongs to; o_done is the exception and trails DONE by a cycle.
   always_comb begin
      codec_rst_n_d = 1'b0;
      tx_en_d       = 1'b0;
      rx_en_d       = 1'b0;
      byte_ready_d  = 1'b0;
      busy_d        = 1'b1;
      done_d        = (state_q == ST_DONE) && !i_abort;
      case (state_d)
         ST_IDLE, ST_DONE: busy_d = 1'b0;
         ST_FLUSH:   codec_rst_n_d = 1'b0;
         ST_LOAD:    begin codec_rst_n_d = 1'b1; byte_ready_d = 1'b1; end
         ST_SEND:    begin codec_rst_n_d = 1'b1; tx_en_d = 1'b1; rx_en_d = 1'b1; end
         ST_WAIT_TX, ST_WAIT_RX: begin codec_rst_n_d = 1'b1; rx_en_d = 1'b1; end
         ST_CHECK:   codec_rst_n_d = 1'b1;
         default:    busy_d = 1'b0;
      endcase
   end

   // ---------------- Datapath: counters, capture, compare ----------------
   always_comb begin
      num_d         = num_q;
      byte_cnt_d    = byte_cnt_q;
      err_cnt_d     = err_cnt_q;
      timeout_d     = timeout_q;
      tx_data_d     = tx_data_q;
      last_rx_d     = last_rx_q;
      rx_pend_d     = rx_pend_q;
      rx_pend_dat_d = rx_pend_dat_q;
      tmo_frm_d     = tmo_frm_q;
      if (!i_abort) begin
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  num_d      = i_num_bytes;
                  byte_cnt_d = '0;
                  err_cnt_d  = '0;
                  timeout_d  = 1'b0;
               end
            end
            ST_LOAD: if (i_byte_valid) tx_data_d = i_byte_data;
            ST_SEND: begin
               rx_pend_d = 1'b0;
               tmo_frm_d = 1'b0;
            end
            ST_WAIT_TX: begin
               if (wd_expire) begin
                  timeout_d = 1'b1;
                  tmo_frm_d = 1'b1;
                  err_cnt_d = err_inc;
               end else if (i_rx_done && !rx_pend_q) begin
                  rx_pend_d     = 1'b1;
                  rx_pend_dat_d = i_rx_data;
               end
            end
            ST_WAIT_RX: begin
               // A receive completing in the expiry cycle beats the watchdog.
               if (rx_hit) begin
                  last_rx_d = rx_byte;
               end else if (wd_expire) begin
                  timeout_d = 1'b1;
                  tmo_frm_d = 1'b1;
                  err_cnt_d = err_inc;
               end
            end
            ST_CHECK: begin
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (!tmo_frm_q && (last_rx_q != tx_data_q)) err_cnt_d = err_inc;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         codec_rst_n_q <= 1'b0;
         tx_en_q       <= 1'b0;
         rx_en_q       <= 1'b0;
         byte_ready_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         num_q         <= '0;
         byte_cnt_q    <= '0;
         err_cnt_q     <= '0;
         timeout_q     <= 1'b0;
         tx_data_q     <= '0;
         last_rx_q     <= '0;
         rx_pend_q     <= 1'b0;
         rx_pend_dat_q <= '0;
         tmo_frm_q     <= 1'b0;
         flush_cnt_q   <= '0;
      end else begin
         codec_rst_n_q <= codec_rst_n_d;
         tx_en_q       <= tx_en_d;
         rx_en_q       <= rx_en_d;
         byte_ready_q  <= byte_ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         num_q         <= num_d;
         byte_cnt_q    <= byte_cnt_d;
         err_cnt_q     <= err_cnt_d;
         timeout_q     <= timeout_d;
         tx_data_q     <= tx_data_d;
         last_rx_q     <= last_rx_d;
         rx_pend_q     <= rx_pend_d;
         rx_pend_dat_q <= rx_pend_dat_d;
         tmo_frm_q     <= tmo_frm_d;
         flush_cnt_q   <= (state_q == ST_FLUSH) ? flush_cnt_q + FCW'(1) : '0;
      end
   end

   assign o_codec_rst_n = codec_rst_n_q;
   assign o_tx_en       = tx_en_q;
   assign o_rx_en       = rx_en_q;
   assign o_byte_ready  = byte_ready_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_tx_data     = tx_data_q;
   assign o_last_rx     = last_rx_q;
   assign o_byte_cnt    = byte_cnt_q;
   assign o_err_cnt     = err_cnt_q;
   assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_vd_loopback_sequencer.sv
// Purpose : self-checking bench for the loopback sequencer (table of runs plus
//           hand-written abort / zero-length / timeout / race sequences).
// Latency : n/a.
// Backpressure: bench presents bytes as soon as o_byte_ready is seen.
module tb_vd_loopback_sequencer;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic       i_abort = 1'b0;
   logic [7:0] i_num_bytes = '0;
   logic       i_byte_valid = 1'b0;
   logic [7:0] i_byte_data = '0;
   logic       o_byte_ready;
   logic       o_tx_en;
   logic [7:0] o_tx_data;
   logic       i_tx_done = 1'b0;
   logic       o_rx_en;
   logic       i_rx_done = 1'b0;
   logic [7:0] i_rx_data = '0;
   logic       o_codec_rst_n;
   logic       o_busy;
   logic       o_done;
   logic [7:0] o_byte_cnt;
   logic [7:0] o_err_cnt;
   logic       o_timeout;
   logic [7:0] o_last_rx;

   int total = 0;
   int bad   = 0;

   // Event counters sampled mid-cycle.
   int n_tx = 0, n_done = 0, n_rdy = 0, n_flush = 0;

   always #5 i_clk = ~i_clk;

   vd_loopback_sequencer #(
      .SIZE_DATA      (8),
      .CNT_W          (8),
      .FLUSH_CYCLES   (4),
      .TIMEOUT_W      (20),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_num_bytes   (i_num_bytes),
      .i_byte_valid  (i_byte_valid),
      .i_byte_data   (i_byte_data),
      .o_byte_ready  (o_byte_ready),
      .o_tx_en       (o_tx_en),
      .o_tx_data     (o_tx_data),
      .i_tx_done     (i_tx_done),
      .o_rx_en       (o_rx_en),
      .i_rx_done     (i_rx_done),
      .i_rx_data     (i_rx_data),
      .o_codec_rst_n (o_codec_rst_n),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_byte_cnt    (o_byte_cnt),
      .o_err_cnt     (o_err_cnt),
      .o_timeout     (o_timeout),
      .o_last_rx     (o_last_rx)
   );

   always @(negedge i_clk) begin
      if (o_tx_en) n_tx <= n_tx + 1;
      if (o_done) n_done <= n_done + 1;
      if (o_byte_ready) n_rdy <= n_rdy + 1;
      if (o_busy && !o_codec_rst_n) n_flush <= n_flush + 1;
   end

   typedef struct {
      logic [7:0]      n;
      logic [2:0][7:0] tx;
      logic [2:0][7:0] rx;
      logic [7:0]      exp_cnt;
      logic [7:0]      exp_err;
      logic [7:0]      exp_last;
      logic            exp_tmo;
   } run_t;

   run_t runs [3];

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic start_run(input logic [7:0] n);
      i_num_bytes = n;
      i_start     = 1'b1;
      tick();
      i_start     = 1'b0;
   endtask

   // Wait for ready, hand over one byte; returns in the launch (o_tx_en) cycle.
   task automatic load_byte(input logic [7:0] d);
      int n = 0;
      while (!o_byte_ready && n < 100) begin
         tick();
         n++;
      end
      chk("byte_ready_wait", o_byte_ready, 1);
      i_byte_valid = 1'b1;
      i_byte_data  = d;
      tick();
      i_byte_valid = 1'b0;
      chk("tx_en_pulse", o_tx_en, 1);
      chk("tx_data", o_tx_data, d);
   endtask

   // One frame; tx_at/rx_at are cycle offsets from the launch cycle (rx_at<0: none).
   task automatic frame(input logic [7:0] d, input logic [7:0] rxd, input int tx_at, input int rx_at);
      int kmax;
      load_byte(d);
      kmax = (rx_at > tx_at) ? rx_at : tx_at;
      for (int k = 1; k <= kmax; k++) begin
         tick();
         i_tx_done = (k == tx_at);
         i_rx_done = (k == rx_at);
         i_rx_data = (k == rx_at) ? rxd : 8'h00;
      end
      tick();
      i_tx_done = 1'b0;
      i_rx_done = 1'b0;
      i_rx_data = 8'h00;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!o_done && n < 300) begin
         tick();
         n++;
      end
      chk(nm, o_done, 1);
   endtask

   initial begin
      int s_tx, s_done, s_rdy, s_flush;

      runs[0] = '{n: 8'd3, tx: {8'hFF, 8'h3C, 8'hA5}, rx: {8'hFF, 8'h3C, 8'hA5},
                  exp_cnt: 8'd3, exp_err: 8'd0, exp_last: 8'hFF, exp_tmo: 1'b0};
      runs[1] = '{n: 8'd2, tx: {8'h00, 8'h3C, 8'h5A}, rx: {8'h00, 8'h3D, 8'h5A},
                  exp_cnt: 8'd2, exp_err: 8'd1, exp_last: 8'h3D, exp_tmo: 1'b0};
      runs[2] = '{n: 8'd1, tx: {8'h00, 8'h00, 8'h00}, rx: {8'h00, 8'h00, 8'h80},
                  exp_cnt: 8'd1, exp_err: 8'd1, exp_last: 8'h80, exp_tmo: 1'b0};

      // ---- reset ----
      repeat (3) tick();
      chk("rst_codec_rst_n", o_codec_rst_n, 0);
      chk("rst_tx_en", o_tx_en, 0);
      chk("rst_rx_en", o_rx_en, 0);
      chk("rst_byte_ready", o_byte_ready, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_byte_cnt", o_byte_cnt, 0);
      chk("rst_err_cnt", o_err_cnt, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_tx_data", o_tx_data, 0);
      chk("rst_last_rx", o_last_rx, 0);
      i_rst_n = 1'b1;
      repeat (2) tick();
      chk("idle_codec_rst_n", o_codec_rst_n, 0);

      // ---- table of normal runs ----
      for (int r = 0; r < 3; r++) begin
         s_tx = n_tx; s_done = n_done; s_rdy = n_rdy; s_flush = n_flush;
         start_run(runs[r].n);
         chk("run_busy", o_busy, 1);
         for (int b = 0; b < int'(runs[r].n); b++) begin
            frame(runs[r].tx[b], runs[r].rx[b], 3, 6);
         end
         wait_done("run_done");
         tick();
         chk("run_byte_cnt", o_byte_cnt, runs[r].exp_cnt);
         chk("run_err_cnt", o_err_cnt, runs[r].exp_err);
         chk("run_last_rx", o_last_rx, runs[r].exp_last);
         chk("run_timeout", o_timeout, runs[r].exp_tmo);
         chk("run_done_pulses", n_done - s_done, 1);
         chk("run_tx_pulses", n_tx - s_tx, runs[r].n);
         chk("run_ready_cycles", n_rdy - s_rdy, runs[r].n);
         chk("run_flush_cycles", n_flush - s_flush, 4 * runs[r].n);
         chk("run_idle_busy", o_busy, 0);
      end

      // ---- receiver never answers: watchdog expiry ----
      start_run(8'd1);
      chk("tmo_start_clears_err", o_err_cnt, 0);
      load_byte(8'h77);
      for (int k = 1; k <= 63; k++) begin
         tick();
         i_tx_done = (k == 3);
      end
      chk("tmo_not_yet", o_timeout, 0);
      tick();
      chk("tmo_set_at_64", o_timeout, 1);
      chk("tmo_err_cnt", o_err_cnt, 1);
      wait_done("tmo_done");
      tick();
      chk("tmo_byte_cnt", o_byte_cnt, 1);
      chk("tmo_err_final", o_err_cnt, 1);
      chk("tmo_sticky", o_timeout, 1);

      // ---- abort in WAIT_RX of byte 2 of 4 ----
      start_run(8'd4);
      chk("abort_start_clr_tmo", o_timeout, 0);
      chk("abort_start_clr_err", o_err_cnt, 0);
      frame(8'h24, 8'h24, 3, 6);
      load_byte(8'h42);
      for (int k = 1; k <= 3; k++) begin
         tick();
         i_tx_done = (k == 2);
      end
      chk("abort_pre_rx_en", o_rx_en, 1);
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      chk("abort_rx_en", o_rx_en, 0);
      chk("abort_codec_rst_n", o_codec_rst_n, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_tx_en", o_tx_en, 0);
      chk("abort_byte_ready", o_byte_ready, 0);
      chk("abort_byte_cnt_hold", o_byte_cnt, 1);
      s_done = n_done;
      repeat (5) tick();
      chk("abort_no_done", n_done - s_done, 0);
      chk("abort_stays_idle", o_busy, 0);

      // ---- zero-length run ----
      s_tx = n_tx; s_rdy = n_rdy;
      start_run(8'd0);
      chk("n0_clears_byte_cnt", o_byte_cnt, 0);
      chk("n0_done_early", o_done, 0);
      chk("n0_busy", o_busy, 0);
      tick();
      chk("n0_done_2cyc", o_done, 1);
      tick();
      chk("n0_done_1cyc_only", o_done, 0);
      chk("n0_no_tx", n_tx - s_tx, 0);
      chk("n0_no_ready", n_rdy - s_rdy, 0);

      // ---- rx during WAIT_TX, then rx coincident with expiry ----
      start_run(8'd2);
      frame(8'hC3, 8'hC3, 5, 2);
      frame(8'h96, 8'h96, 5, 63);
      chk("race_no_timeout_at_64", o_timeout, 0);
      wait_done("race_done");
      tick();
      chk("race_timeout", o_timeout, 0);
      chk("race_err_cnt", o_err_cnt, 0);
      chk("race_byte_cnt", o_byte_cnt, 2);
      chk("race_last_rx", o_last_rx, 8'h96);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vd_loopback_sequencer.md
Name: vd_loopback_sequencer

Overview:
- Frame-level controller for the UART-TX -> convolutional encoder -> Viterbi decoder -> UART-RX loopback path.
- Accepts a run of N bytes over a valid/ready stream and, per byte:
  - flushes encoder/decoder state through a dedicated codec reset,
  - launches the transmitter,
  - waits for the receiver (with timeout),
  - compares the received byte against the sent byte.
- Replaces ad-hoc reset gating of the codec with an explicit, sequenced per-frame flush.
- Reports byte count, error count and timeout status for on-board self-test.

Parameters:
- SIZE_DATA, 8, UART payload width.
- CNT_W, 8, width of run-length, byte and error counters.
- FLUSH_CYCLES, 4, cycles o_codec_rst_n is held low before each frame (must be >= 1).
- TIMEOUT_W, 20, width of the receive watchdog counter.
- TIMEOUT_CYCLES, 200000, cycles allowed from tx launch to rx_done (covers ~10 bit times at 325x16 plus decoder latency).

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; begins a run when idle.
- i_abort  in  1  level; forces return to IDLE from any state.
- i_num_bytes  in  CNT_W  bytes in run; sampled at i_start.
- i_byte_valid  in  1  source byte available.
- i_byte_data  in  SIZE_DATA  source byte.
- o_byte_ready  out  1  byte accepted this cycle when valid&ready.
- o_tx_en  out  1  one-cycle transmitter start pulse.
- o_tx_data  out  SIZE_DATA  registered byte under transmission.
- i_tx_done  in  1  transmitter frame complete pulse.
- o_rx_en  out  1  receiver enable.
- i_rx_done  in  1  receiver byte complete pulse.
- i_rx_data  in  SIZE_DATA  received byte, valid with i_rx_done.
- o_codec_rst_n  out  1  synchronous active-low reset to encoder and decoder.
- o_busy  out  1  high in any state except IDLE and DONE.
- o_done  out  1  one-cycle pulse at end of run.
- o_byte_cnt  out  CNT_W  frames completed in current run.
- o_err_cnt  out  CNT_W  mismatches plus timeouts; saturates at all-ones.
- o_timeout  out  1  sticky; set on any watchdog expiry; cleared at i_start.
- o_last_rx  out  SIZE_DATA  last received byte.

Behaviour:
- Reset: FSM=IDLE; o_codec_rst_n=0; o_tx_en=0; o_rx_en=0; o_byte_ready=0; o_busy=0; o_done=0; all counters, o_tx_data and o_last_rx = 0; o_timeout=0.
- All outputs are registered.
- States: IDLE, FLUSH, LOAD, SEND, WAIT_TX, WAIT_RX, CHECK, DONE.
- IDLE:
  - o_codec_rst_n=0.
  - On i_start: latch i_num_bytes; clear o_byte_cnt, o_err_cnt and o_timeout.
  - Go to DONE if N=0, else FLUSH.
  - i_start is ignored in every other state.
- FLUSH: o_codec_rst_n=0 for exactly FLUSH_CYCLES cycles, then LOAD.
- LOAD:
  - o_codec_rst_n=1; o_byte_ready=1.
  - On i_byte_valid: register byte into o_tx_data, go to SEND.
  - Waits indefinitely; no timeout.
- SEND:
  - o_tx_en=1 for one cycle; o_rx_en=1 from here until CHECK.
  - Clear watchdog; go to WAIT_TX.
- WAIT_TX:
  - Wait for i_tx_done, then WAIT_RX.
  - An i_rx_done arriving in WAIT_TX is latched (data included) and honoured on entry to WAIT_RX.
- WAIT_RX:
  - Go to CHECK on i_rx_done (or latched done), capturing i_rx_data into o_last_rx.
  - Watchdog counts from SEND. When it reaches TIMEOUT_CYCLES-1 in WAIT_TX or WAIT_RX: set o_timeout, increment o_err_cnt (saturating), go to CHECK with the compare suppressed.
  - An i_rx_done coinciding with the expiry cycle wins; no timeout is recorded.
- CHECK (1 cycle):
  - If rx byte != o_tx_data and no timeout, increment o_err_cnt (saturating).
  - Increment o_byte_cnt; o_rx_en=0.
  - If o_byte_cnt+1 == N, go to DONE; else FLUSH.
- DONE: o_done pulse for one cycle, then IDLE.
- i_abort (any state): next cycle IDLE; o_tx_en/o_rx_en/o_byte_ready deassert, o_codec_rst_n=0. Counters hold; no o_done.
- Stray i_tx_done or i_rx_done pulses in IDLE/FLUSH/LOAD are ignored and not latched.
- N=all-ones is legal; o_byte_cnt does not wrap within a run.

Decomposition:
- Package vd_seq_pkg holds:
  - state_e enum (8 states, 3-bit encoding),
  - FLUSH counter width as $clog2(FLUSH_CYCLES+1),
  - localparam ERR_MAX = all-ones of CNT_W.
- One sub-module: vd_seq_watchdog. It is a loadable down-counter with clear, enable and expire outputs, parameterised by TIMEOUT_W and TIMEOUT_CYCLES.
- FSM, counters and compare stay in the top.

Test Plan:
- N=3, bytes 0xA5, 0x3C, 0xFF; model loops back correctly -> o_byte_cnt=3, o_err_cnt=0, one o_done pulse, o_timeout=0, o_codec_rst_n low for 4 cycles before each of the 3 o_tx_en pulses.
- N=2; model corrupts the second byte to 0x3D -> o_err_cnt=1, o_last_rx=0x3D, o_byte_cnt=2.
- N=1; model never asserts i_rx_done; TIMEOUT_CYCLES=64 -> o_timeout=1 and o_err_cnt=1 after 64 cycles from o_tx_en; o_done follows.
- N=0 at i_start -> o_done 2 cycles after i_start; no o_tx_en and no o_byte_ready.
- i_abort asserted in WAIT_RX of byte 2 of 4 -> IDLE next cycle, o_rx_en=0, o_codec_rst_n=0, no o_done; a following i_start clears the counters.
- i_rx_done injected during WAIT_TX, and i_rx_done coincident with watchdog expiry -> both complete CHECK with o_timeout=0 and a correct compare.
